// File: rtl/siso_rr_arbiter_if.sv
// Bundle of the per-requester input streams and the single buffered SISO output.
// The arbiter takes the slave side; the driving environment takes the master side.
interface siso_rr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]                 req_valid_i;
   logic [NUM_REQ-1:0]                 req_last_i;
   logic [NUM_REQ-1:0]                 req_ready_o;
   logic [DATA_WIDTH-1:0]              data_out;
   logic                               data_out_valid;
   logic                               data_out_last;
   logic                               data_out_ready;
   logic [IDX_W-1:0]                   grant_idx_o;
   logic                               busy_o;

   modport slave (
      input  req_data_i, req_valid_i, req_last_i, data_out_ready,
      output req_ready_o, data_out, data_out_valid, data_out_last, grant_idx_o, busy_o
   );

   modport master (
      output req_data_i, req_valid_i, req_last_i, data_out_ready,
      input  req_ready_o, data_out, data_out_valid, data_out_last, grant_idx_o, busy_o
   );
endinterface

// File: rtl/siso_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_REQ input streams share one registered output.
// A packet keeps the grant until its last beat is accepted; the pointer then moves past the winner.
module siso_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic                 clk_i,
   input logic                 arst_n,
   siso_rr_arbiter_if.slave    bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]            state_q,     state_d;
   logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;
   logic [IDX_W-1:0]      lock_idx_q,  lock_idx_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q,  out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [IDX_W-1:0]      out_idx_q,   out_idx_d;

   logic                  can_accept;
   logic                  win_valid;
   logic [IDX_W-1:0]      win_idx;
   logic [NUM_REQ-1:0]    win_sel;
   logic                  accept;
   logic                  win_last;
   logic [DATA_WIDTH-1:0] win_data;
   logic [IDX_W-1:0]      ptr_next;

   assign can_accept = ~out_valid_q | bus.data_out_ready;

   // Locked packets own the grant outright; otherwise search from rr_ptr with wrap.
   always_comb begin
      int cand;
      cand      = 0;
      win_valid = 1'b0;
      win_idx   = '0;
      if (state_q == ST_LOCKED) begin
         win_valid = 1'b1;
         win_idx   = lock_idx_q;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_valid && bus.req_valid_i[cand]) begin
               win_valid = 1'b1;
               win_idx   = IDX_W'(cand);
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign win_sel[gi] = win_valid && (win_idx == IDX_W'(gi));
   end

   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_sel[k]) win_data = win_data | bus.req_data_i[k];
      end
   end

   assign accept   = can_accept & |(win_sel & bus.req_valid_i);
   assign win_last = |(win_sel & bus.req_last_i);
   assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_idx_d  = lock_idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_last_d  = win_last;
         out_data_d  = win_data;
         out_idx_d   = win_idx;
         if (win_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = ptr_next;
         end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = win_idx;
         end
      end else if (bus.data_out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         lock_idx_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_idx_q  <= lock_idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

   // Ready is gated by reset so no requester sees a handshake while the block is held.
   assign bus.req_ready_o    = arst_n ? (win_sel & {NUM_REQ{can_accept}}) : '0;
   assign bus.data_out       = out_data_q;
   assign bus.data_out_valid = out_valid_q;
   assign bus.data_out_last  = out_last_q;
   assign bus.grant_idx_o    = out_idx_q;
   assign bus.busy_o         = (state_q == ST_LOCKED) | out_valid_q;

endmodule

// File: tb/tb_siso_rr_arbiter.sv
// Bench for siso_rr_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_siso_rr_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;

   siso_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

   siso_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
      .clk_i  (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: which packet owns the stream, where the next search starts, what sits in the buffer.
   bit         m_locked;
   int         m_lock;
   int         m_ptr;
   bit         m_bv;
   bit         m_bl;
   logic [7:0] m_bd;
   int         m_bi;

   int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_lock = 0; m_ptr = 0;
      m_bv = 0; m_bl = 0; m_bd = '0; m_bi = 0;
   endtask

   // One clock: check outputs against the model, then advance the model over the edge.
   task automatic step();
      int         w;
      bit         has, can, acc;
      logic [N-1:0] exp_rdy;
      logic [7:0] wd;
      bit         wl;
      #1;
      chk("out_valid", 32'(bus.data_out_valid), 32'(m_bv));
      if (m_bv) begin
         chk("out_data", 32'(bus.data_out), 32'(m_bd));
         chk("out_last", 32'(bus.data_out_last), 32'(m_bl));
         chk("out_idx", 32'(bus.grant_idx_o), 32'(m_bi));
      end
      chk("busy", 32'(bus.busy_o), 32'(m_locked | m_bv));
      can = !m_bv || bus.data_out_ready;
      has = 0;
      w   = 0;
      if (m_locked) begin
         has = 1;
         w   = m_lock;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!has && bus.req_valid_i[(m_ptr + k) % N]) begin
               has = 1;
               w   = (m_ptr + k) % N;
            end
         end
      end
      exp_rdy = (has && can) ? N'(1 << w) : '0;
      chk("ready", 32'(bus.req_ready_o), 32'(exp_rdy));
      acc = has && can && bus.req_valid_i[w];
      wd  = bus.req_data_i[w];
      wl  = bus.req_last_i[w];
      @(posedge clk);
      if (acc) begin
         m_bv = 1; m_bd = wd; m_bl = wl; m_bi = w;
         if (wl) begin
            m_locked = 0;
            m_ptr    = (w + 1) % N;
         end else begin
            m_locked = 1;
            m_lock   = w;
         end
         $display("beat: req%0d data=%02h last=%0b", w, wd, wl);
      end else if (bus.data_out_ready) begin
         m_bv = 0;
      end
      @(negedge clk);
   endtask

   // Assert reset mid-cycle with every requester valid; all outputs must sit at reset values.
   task automatic apply_reset();
      bus.req_valid_i = '1;
      #2 arst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_last", 32'(bus.data_out_last), 32'd0);
      chk("rst_idx", 32'(bus.grant_idx_o), 32'd0);
      model_reset();
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   initial begin
      bus.req_valid_i    = '0;
      bus.req_last_i     = '0;
      bus.req_data_i     = '0;
      bus.data_out_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);

      // Round robin over single-beat packets.
      apply_reset();
      bus.req_valid_i = 4'hF;
      bus.req_last_i  = 4'hF;
      for (int r = 0; r < N; r++) bus.req_data_i[r] = 8'(8'h10 * r);
      for (int k = 0; k < 7; k++) begin
         if (k > 0) chk("rr_seq", 32'(bus.grant_idx_o), 32'(rr_exp[k-1]));
         step();
      end

      // Packet lock: req0 three beats, req1 waiting.
      apply_reset();
      bus.req_valid_i   = 4'b0011;
      bus.req_last_i    = 4'b0010;
      bus.req_data_i[1] = 8'hB0;
      for (int b = 0; b < 3; b++) begin
         bus.req_data_i[0] = 8'(8'hA0 + b);
         bus.req_last_i[0] = (b == 2);
         #1 chk("lock_rdy1", 32'(bus.req_ready_o[1]), 32'd0);
         step();
         chk("lock_out", 32'(bus.data_out), 32'(8'hA0 + b));
      end
      bus.req_valid_i = 4'b0010;
      step();
      chk("lock_next_data", 32'(bus.data_out), 32'h00B0);
      chk("lock_next_idx", 32'(bus.grant_idx_o), 32'd1);

      // Backpressure holds the buffered beat.
      apply_reset();
      bus.req_valid_i   = 4'b0001;
      bus.req_last_i    = 4'b0001;
      bus.req_data_i[0] = 8'h5A;
      step();
      bus.req_data_i[0]  = 8'h6B;
      bus.data_out_ready = 1'b0;
      repeat (3) begin
         #1;
         chk("bp_data", 32'(bus.data_out), 32'h005A);
         chk("bp_ready", 32'(bus.req_ready_o), 32'd0);
         step();
      end
      bus.data_out_ready = 1'b1;
      step();
      chk("bp_next", 32'(bus.data_out), 32'h006B);

      // Bubble inside a locked packet on req2.
      apply_reset();
      bus.req_valid_i   = 4'b1100;
      bus.req_last_i    = 4'b1000;
      bus.req_data_i[2] = 8'h20;
      bus.req_data_i[3] = 8'h30;
      step();
      bus.req_valid_i = 4'b1000;
      repeat (2) begin
         #1 chk("bubble_rdy3", 32'(bus.req_ready_o[3]), 32'd0);
         step();
      end
      bus.req_valid_i   = 4'b1100;
      bus.req_last_i    = 4'b1100;
      bus.req_data_i[2] = 8'h21;
      #1 chk("bubble_rdy3_last", 32'(bus.req_ready_o[3]), 32'd0);
      step();
      chk("bubble_end_idx", 32'(bus.grant_idx_o), 32'd2);
      bus.req_valid_i = 4'b1000;
      step();
      chk("bubble_then3", 32'(bus.grant_idx_o), 32'd3);

      // Reset mid-packet, then wrap after a grant to req3.
      apply_reset();
      bus.req_valid_i   = 4'b0010;
      bus.req_last_i    = 4'b0000;
      bus.req_data_i[1] = 8'h11;
      step();
      apply_reset();
      bus.req_valid_i   = 4'b1010;
      bus.req_last_i    = 4'b1010;
      bus.req_data_i[1] = 8'h12;
      bus.req_data_i[3] = 8'h33;
      step();
      chk("rst_first_idx", 32'(bus.grant_idx_o), 32'd1);
      chk("rst_first_data", 32'(bus.data_out), 32'h0012);
      bus.req_valid_i = 4'b1000;
      step();
      chk("wrap_grant3", 32'(bus.grant_idx_o), 32'd3);
      bus.req_valid_i   = 4'b0101;
      bus.req_last_i    = 4'b0101;
      bus.req_data_i[0] = 8'h40;
      bus.req_data_i[2] = 8'h42;
      step();
      chk("wrap_grant0", 32'(bus.grant_idx_o), 32'd0);
      chk("wrap_data0", 32'(bus.data_out), 32'h0040);

      // Random traffic with occasional reset.
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) apply_reset();
         bus.req_valid_i = N'($urandom);
         for (int r = 0; r < N; r++) begin
            bus.req_data_i[r] = 8'($urandom);
            bus.req_last_i[r] = ($urandom_range(0, 2) == 0);
         end
         bus.data_out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
